// File: rtl/boot_defs.sv
// Shared definitions for the instruction-RAM boot loader.
// Optional idle timeout is enabled with BOOT_TIMEOUT_EN.
package boot_defs;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

  function automatic logic too_big(
    input logic [31:0] n,
    input int          aw
  );
    return {1'b0, n} > (33'd1 << aw);
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Little-endian byte-to-word shift register for the boot loader.
// First byte of a word lands in bits [7:0].
module boot_word_assembler
  import boot_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  assign word_valid = byte_valid &&
    (cnt == 2'(BYTES_PER_WORD - 1));
  assign word = {byte_data, sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (byte_valid) begin
      sr  <= {byte_data, sr[23:8]};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream loader that writes a checksummed image into imem.
// Define BOOT_TIMEOUT_EN to abort on an over-long mid-image gap.
module imem_boot_loader
  import boot_defs::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  boot_done,
  output logic                  boot_err
);

  state_t                state, nxt;
  logic                  acc, asm_v, wv, wr;
  logic [31:0]           word;
  logic [ADDR_WIDTH-1:0] widx, nlast;
  logic [CSUM_W-1:0]     csum;
  logic                  tmo;

  assign in_ready = !rstn &&
    (state == S_LEN || state == S_DATA || state == S_CSUM);
  assign acc   = in_valid && in_ready;
  assign asm_v = acc && (state == S_LEN || state == S_DATA);
  assign wr    = wv && (state == S_DATA);

  assign boot_done = (state == S_DONE);
  assign boot_err  = (state == S_ERR);
  assign cpu_hold  = !boot_done;

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rstn),
    .clr        (nxt != state),
    .byte_valid (asm_v),
    .byte_data  (in_data),
    .word_valid (wv),
    .word       (word)
  );

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] idle;
  logic        started, idle_on;

  assign idle_on = state == S_DATA || state == S_CSUM ||
    (state == S_LEN && started);
  assign tmo = idle_on && !acc &&
    (idle == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      idle    <= '0;
      started <= 1'b0;
    end else begin
      started <= (state == S_LEN) && (started || acc);
      if (acc || !idle_on) idle <= '0;
      else                 idle <= idle + 32'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      S_LEN: if (wv) begin
        if (too_big(word, ADDR_WIDTH)) nxt = S_ERR;
        else if (word == '0)           nxt = S_CSUM;
        else                           nxt = S_DATA;
      end
      S_DATA: if (wv && widx == nlast) nxt = S_CSUM;
      S_CSUM: if (acc) begin
        nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
      default: nxt = state;
    endcase
    if (tmo) nxt = S_ERR;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= S_LEN;
      widx       <= '0;
      nlast      <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= nxt;
      imem_we <= wr;
      if (asm_v) csum <= csum + in_data;
      if (state == S_LEN && wv) begin
        nlast <= ADDR_WIDTH'(word - 32'd1);
        widx  <= '0;
      end
      // hold the index at the last word so N = capacity never wraps
      if (wr) begin
        imem_waddr <= widx;
        imem_wdata <= word;
        if (widx != nlast) widx <= widx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: vector table plus
// hand-written timing, oversize and mid-image reset sequences.
module tb_imem_boot_loader;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_err;

  imem_boot_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    int          nw;
    int          delta;
    int          gap;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          done;
    bit          err;
  } row_t;

  int  checks = 0;
  int  failures = 0;
  int  both_cnt = 0;
  wr_t got[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) got.push_back('{32'(imem_waddr), imem_wdata});
    if (boot_done && boot_err) both_cnt++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b,
                           input int gap,
                           output bit ok);
    int g = 0;
    while (g < 20 && int'($urandom_range(99)) < gap) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      @(negedge clk);
      g++;
    end
    ok = in_ready;
    if (!ok) return;
    in_valid = 1'b1;
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic build(input logic [31:0] n,
                       input logic [31:0] w[$],
                       input int delta,
                       output logic [7:0] b[$]);
    logic [7:0] sum = 8'h00;
    b.delete();
    for (int k = 0; k < 4; k++) b.push_back(n[8*k +: 8]);
    foreach (w[i])
      for (int k = 0; k < 4; k++) b.push_back(w[i][8*k +: 8]);
    foreach (b[i]) sum = sum + b[i];
    b.push_back(sum + 8'(delta));
  endtask

  task automatic run_row(input row_t r, input string tag,
                         input bit rst_first);
    logic [31:0] w[$];
    logic [7:0]  b[$];
    wr_t         exp[$];
    int          nmax;
    bit          ok;
    for (int i = 0; i < r.nw; i++)
      w.push_back(i == 0 ? r.w0 : i == 1 ? r.w1 : $urandom);
    build(r.n, w, r.delta, b);
    nmax = (r.n > 32'd256) ? 0 : int'(r.n);
    for (int i = 0; i < r.nw && i < nmax; i++)
      exp.push_back('{32'(i), w[i]});
    if (rst_first) do_reset();
    got.delete();
    foreach (b[i]) begin
      send_byte(b[i], r.gap, ok);
      if (!ok) break;
    end
    repeat (3) @(negedge clk);
    chk({tag, " nwr"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s addr%0d", tag, i), got[i].a, exp[i].a);
      chk($sformatf("%s data%0d", tag, i), got[i].d, exp[i].d);
    end
    chk({tag, " done"}, boot_done, r.done);
    chk({tag, " err"}, boot_err, r.err);
    chk({tag, " hold"}, cpu_hold, !r.done);
    chk({tag, " rdy"}, in_ready, 1'b0);
  endtask

  row_t rows[7];
  logic [7:0] img[$];
  logic [31:0] wq[$];
  bit ok;

  initial begin
    rows[0] = '{2, 2, 0, 0, 32'h293, 32'h313, 1, 0};
    rows[1] = '{0, 0, 0, 0, 0, 0, 1, 0};
    rows[2] = '{1, 1, 1, 0, 32'h13, 0, 0, 1};
    rows[3] = '{257, 0, 0, 0, 0, 0, 0, 1};
    rows[4] = '{256, 256, 0, 10, $urandom, $urandom, 1, 0};
    rows[5] = '{3, 3, 0, 50, $urandom, $urandom, 1, 0};
    rows[6] = '{5, 5, 0, 30, $urandom, $urandom, 1, 0};

    rstn = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    #3;
    chk("rst rdy", in_ready, 1'b0);
    chk("rst we", imem_we, 1'b0);
    chk("rst addr", imem_waddr, 8'h00);
    chk("rst data", imem_wdata, 32'h0);
    chk("rst hold", cpu_hold, 1'b1);
    chk("rst done", boot_done, 1'b0);
    chk("rst err", boot_err, 1'b0);

    foreach (rows[i]) run_row(rows[i], $sformatf("row%0d", i), 1'b1);

    // Write latency and cpu_hold release timing at full rate.
    do_reset();
    wq = '{32'h293, 32'h313};
    build(32'd2, wq, 0, img);
    for (int i = 0; i < 7; i++) send_byte(img[i], 0, ok);
    chk("lat we0", imem_we, 1'b0);
    send_byte(img[7], 0, ok);
    chk("lat we1", imem_we, 1'b1);
    chk("lat addr", imem_waddr, 8'h00);
    chk("lat data", imem_wdata, 32'h293);
    for (int i = 8; i < 12; i++) send_byte(img[i], 0, ok);
    chk("lat hold1", cpu_hold, 1'b1);
    send_byte(img[12], 0, ok);
    chk("lat hold0", cpu_hold, 1'b0);
    chk("lat done", boot_done, 1'b1);

    // Oversize length fails on the 4th length byte.
    do_reset();
    got.delete();
    wq = '{};
    build(32'd257, wq, 0, img);
    for (int i = 0; i < 4; i++) send_byte(img[i], 0, ok);
    chk("ovr err", boot_err, 1'b1);
    chk("ovr rdy", in_ready, 1'b0);
    chk("ovr nwr", got.size(), 0);

    // Reset in the middle of an N=4 image, then a fresh N=1 image.
    do_reset();
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    build(32'd4, wq, 0, img);
    for (int i = 0; i < 12; i++) send_byte(img[i], 0, ok);
    rstn = 1'b1;
    #1;
    chk("mid rdy", in_ready, 1'b0);
    chk("mid we", imem_we, 1'b0);
    chk("mid addr", imem_waddr, 8'h00);
    chk("mid data", imem_wdata, 32'h0);
    chk("mid hold", cpu_hold, 1'b1);
    chk("mid done", boot_done, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    run_row('{1, 1, 0, 20, 32'h00500093, 0, 1, 0}, "reimg", 1'b0);

`ifdef BOOT_TIMEOUT_EN
    do_reset();
    build(32'd2, wq, 0, img);
    for (int i = 0; i < 5; i++) send_byte(img[i], 0, ok);
    repeat (1030) @(negedge clk);
    chk("tmo err", boot_err, 1'b1);
`endif

    chk("excl", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
